// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the two-requester ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: wrapping add/sub, bitwise ops, zero-extended signed/unsigned compares.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU; one operation in flight at a time.
//
//   state   | meaning
//   IDLE    | waiting for a request, req_ready offered to the granted requester
//   EXEC    | captured operands going through the ALU, result registered at end
//   DONE    | result presented on res_valid until the consumer accepts it
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [5:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_id,
   output logic [WIDTH-1:0]   res_data,
   output logic               busy
);

   state_e           state;
   logic             last_grant;
   logic             grant_id;
   logic             xfer;
   logic [2:0]       cap_op;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic             cap_id;
   logic [WIDTH-1:0] alu_result;

   always_comb begin
      grant_id = 1'b0;
      case (req_valid)
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
   end

   // Gated by rst_n so nothing looks acceptable while the registers are held clear.
   always_comb begin
      req_ready = 2'b00;
      if (rst_n && (state == ST_IDLE)) begin
         req_ready = req_valid & (grant_id ? 2'b10 : 2'b01);
      end
   end

   assign xfer = |req_ready;

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .op     (cap_op),
      .a      (cap_a),
      .b      (cap_b),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_id     <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_id     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  cap_op     <= grant_id ? req_op[5:3] : req_op[2:0];
                  cap_a      <= grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                  cap_b      <= grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                  cap_id     <= grant_id;
                  last_grant <= grant_id;
                  busy       <= 1'b1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_data  <= alu_result;
               res_id    <= cap_id;
               res_valid <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a cycle-level reference model.
module tb_alu_arbiter;

   localparam int WIDTH = 32;

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               v0, v1;
   logic [2:0]         op0, op1;
   logic [WIDTH-1:0]   a0, a1, b0, b1;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [5:0]         req_op;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               res_valid;
   logic               res_ready;
   logic               res_id;
   logic [WIDTH-1:0]   res_data;
   logic               busy;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   bit   rand_done;

   assign req_valid = {v1, v0};
   assign req_op    = {op1, op0};
   assign req_a     = {a1, a0};
   assign req_b     = {b1, b0};

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~(a | b);
         3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return (a < b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h0000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Reference model: one operation outstanding; result visible two cycles after acceptance.
   initial begin
      bit         busy_m;
      bit         last_m;
      int         age;
      bit         exp_rv;
      bit         g;
      logic [1:0] exp_ready;
      exp_t       e;
      busy_m = 0;
      last_m = 1;
      age    = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_m = 0;
            last_m = 1;
            age    = 0;
            sb.delete();
            chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
            chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
            continue;
         end
         exp_rv = busy_m && (age >= 2);
         chk("res_valid", {63'd0, res_valid}, {63'd0, exp_rv});
         chk("busy", {63'd0, busy}, {63'd0, busy_m});
         exp_ready = 2'b00;
         g = 0;
         if (!busy_m && req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? !last_m : req_valid[1];
            exp_ready = g ? 2'b10 : 2'b01;
         end
         chk("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
         if (exp_ready != 2'b00) begin
            e.id   = g;
            e.data = g ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
            sb.push_back(e);
            last_m = g;
            busy_m = 1;
            age    = 1;
         end else if (busy_m) begin
            if (exp_rv && res_ready) busy_m = 0;
            else age++;
         end
      end
   end

   // Monitor: pops an expectation on each new result and checks it stays put until accepted.
   initial begin
      bit   holding;
      exp_t e;
      holding = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !res_valid) begin
            holding = 0;
            continue;
         end
         if (!holding) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", {32'd0, res_data}, 64'hDEAD);
               e.id   = res_id;
               e.data = res_data;
            end else begin
               e = sb.pop_front();
               chk("res_data", {32'd0, res_data}, {32'd0, e.data});
               chk("res_id", {63'd0, res_id}, {63'd0, e.id});
            end
            holding = 1;
         end else begin
            chk("hold_data", {32'd0, res_data}, {32'd0, e.data});
            chk("hold_id", {63'd0, res_id}, {63'd0, e.id});
         end
         if (res_ready) holding = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input bit id, input bit v, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (id) begin
         v1 = v; op1 = op; a1 = a; b1 = b;
      end else begin
         v0 = v; op0 = op; a0 = a; b0 = b;
      end
   endtask

   // Raise a request and hold it until granted; operands are scrambled after the transfer.
   task automatic send(input bit id, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bit got;
      got = 0;
      set_req(id, 1'b1, op, a, b);
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      if (!got) chk(id ? "grant_timeout1" : "grant_timeout0", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      set_req(id, 1'b0, 3'($urandom), $urandom, $urandom);
   endtask

   // One-cycle request that may be withdrawn before it is granted.
   task automatic blip(input bit id);
      set_req(id, 1'b1, 3'($urandom), pick(), pick());
      @(posedge clk);
      #1;
      set_req(id, 1'b0, 3'($urandom), $urandom, $urandom);
   endtask

   task automatic rand_requester(input bit id, input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         if ($urandom_range(0, 7) == 0) blip(id);
         else send(id, 3'($urandom), pick(), pick());
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      res_ready = 1'b0;
      rand_done = 0;
      set_req(1'b0, 1'b1, 3'd0, 32'h1, 32'h2);
      set_req(1'b1, 1'b1, 3'd0, 32'h3, 32'h4);
      #1;
      chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
      chk("reset_res_data", {32'd0, res_data}, 64'd0);
      chk("reset_res_id", {63'd0, res_id}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
      #1;
      rst_n = 1'b1;
      res_ready = 1'b1;

      send(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
      send(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
      send(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0000_0001);

      fork
         send(1'b0, 3'd1, 32'd5, 32'd3);
         send(1'b1, 3'd2, 32'h0000_F0F0, 32'h0000_0FF0);
      join
      fork
         send(1'b0, 3'd5, 32'h0F0F_0000, 32'h0000_00FF);
         send(1'b1, 3'd4, 32'hAAAA_5555, 32'h5555_5555);
      join

      repeat (2) @(posedge clk);
      #1;
      res_ready = 1'b0;
      send(1'b0, 3'd3, 32'h0000_1234, 32'h0000_5600);
      fork
         send(1'b1, 3'd0, 32'd10, 32'd20);
         begin
            repeat (6) @(posedge clk);
            #1;
            res_ready = 1'b1;
         end
      join

      repeat (3) @(posedge clk);
      #1;
      send(1'b0, 3'd0, 32'd7, 32'd8);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_res_valid", {63'd0, res_valid}, 64'd0);
      chk("async_busy", {63'd0, busy}, 64'd0);
      chk("async_res_data", {32'd0, res_data}, 64'd0);
      chk("async_res_id", {63'd0, res_id}, 64'd0);
      chk("async_req_ready", {62'd0, req_ready}, 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_stale_result", {63'd0, res_valid}, 64'd0);
      @(posedge clk);
      #1;
      fork
         send(1'b0, 3'd1, 32'd1, 32'd2);
         send(1'b1, 3'd0, 32'd100, 32'd200);
      join

      fork
         begin
            fork
               rand_requester(1'b0, 150);
               rand_requester(1'b1, 150);
            join
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               res_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join

      #1;
      res_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
